// File: rtl/system_0_sysid_ext.sv
// System ID, build timestamp, 64-bit prescaled uptime with coherent HI snapshot, scratch and run/clear control.
// Read latency 1 via readdatavalid, no waitrequest: one transaction is accepted every cycle.
module system_0_sysid_ext #(
    parameter logic [31:0] ID_VALUE      = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP     = 32'h5D2F_8C3C,
    parameter int          ADDR_W        = 3,
    parameter int          TICK_DIV      = 50,
    parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam int            PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PTERM = PW'(TICK_DIV - 1);

    localparam logic [2:0] W_ID      = 3'd0;
    localparam logic [2:0] W_TS      = 3'd1;
    localparam logic [2:0] W_UP_LO   = 3'd2;
    localparam logic [2:0] W_UP_HI   = 3'd3;
    localparam logic [2:0] W_SCRATCH = 3'd4;
    localparam logic [2:0] W_CTRL    = 3'd5;
    localparam logic [2:0] W_DIV     = 3'd6;
    localparam logic [2:0] W_INFO    = 3'd7;

    logic [PW-1:0] pcnt;
    logic [63:0]   uptime;
    logic [31:0]   shadow;
    logic [31:0]   scratch;
    logic          run;

    logic          rd_acc;
    logic          wr_acc;
    logic          in_map;
    logic [2:0]    word;
    logic          wr_scratch;
    logic          wr_ctrl;
    logic          clr;
    logic          tick;
    logic          snap;
    logic [31:0]   rd_mux;

    assign rd_acc     = chipselect & read;
    assign wr_acc     = chipselect & write;
    // Only the low eight words are decoded; anything above reads 0 and ignores writes.
    assign in_map     = ((address >> 3) == '0);
    assign word       = address[2:0];
    assign wr_scratch = wr_acc & in_map & (word == W_SCRATCH);
    assign wr_ctrl    = wr_acc & in_map & (word == W_CTRL) & byteenable[0];
    assign clr        = wr_ctrl & writedata[1];
    assign tick       = run & (pcnt == PTERM);
    assign snap       = rd_acc & in_map & (word == W_UP_LO);

    always_comb begin
        rd_mux = '0;
        if (in_map) begin
            case (word)
                W_ID:      rd_mux = ID_VALUE;
                W_TS:      rd_mux = TIMESTAMP;
                W_UP_LO:   rd_mux = uptime[31:0];
                W_UP_HI:   rd_mux = shadow;
                W_SCRATCH: rd_mux = scratch;
                W_CTRL:    rd_mux = {31'd0, run};
                W_DIV:     rd_mux = 32'(TICK_DIV);
                W_INFO:    rd_mux = {16'd1, 8'd0, 8'(ADDR_W)};
                default:   rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            pcnt          <= '0;
            uptime        <= '0;
            shadow        <= '0;
            scratch       <= SCRATCH_RESET;
            run           <= 1'b1;
        end else begin
            readdatavalid <= rd_acc;
            // rd_mux samples pre-edge state, so a coincident write or tick is not visible to this read.
            if (rd_acc) begin
                readdata <= rd_mux;
            end
            if (snap) begin
                shadow <= uptime[63:32];
            end
            if (wr_scratch) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        scratch[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            if (wr_ctrl) begin
                run <= writedata[0];
            end
            if (clr) begin
                pcnt   <= '0;
                uptime <= '0;
            end else if (tick) begin
                pcnt   <= '0;
                uptime <= uptime + 64'd1;
            end else if (run) begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_system_0_sysid_ext.sv
// Directed bench for system_0_sysid_ext: scoreboarded reads, readdata hold, uptime, snapshot, CLR and reset checks.
module tb_system_0_sysid_ext;

    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [31:0]   writedata = '0;
    logic [3:0]    byteenable = '0;
    logic [31:0]   readdata;
    logic          readdatavalid;

    int            n_vec = 0;
    int            n_bad = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   last_rd = '0;

    always #5 clock = ~clock;

    system_0_sysid_ext #(
        .ID_VALUE      (32'hCAFE_0001),
        .TIMESTAMP     (32'h5D2F_8C3C),
        .ADDR_W        (AW),
        .TICK_DIV      (4),
        .SCRATCH_RESET (32'h0000_0000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .address       (address),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .readdata      (readdata),
        .readdatavalid (readdatavalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pass one rising edge, then check valid and data on the falling edge.
    task automatic clk1();
        logic ev;
        logic rs;
        ev = chipselect && read && !reset;
        rs = reset;
        @(negedge clock);
        check("rdv", {31'd0, readdatavalid}, {31'd0, ev});
        if (rs) begin
            last_rd = '0;
        end else if (ev && exp_q.size() > 0) begin
            last_rd = exp_q.pop_front();
        end
        check("rdata", readdata, last_rd);
    endtask

    task automatic idle(input int n);
        repeat (n) clk1();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [31:0] e);
        chipselect = 1'b1; read = 1'b1; address = a;
        exp_q.push_back(e);
        clk1();
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
        clk1();
        chipselect = 1'b0; write = 1'b0; byteenable = '0;
    endtask

    task automatic rdwr(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] e);
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = 4'hF;
        exp_q.push_back(e);
        clk1();
        chipselect = 1'b0; read = 1'b0; write = 1'b0; byteenable = '0;
    endtask

    initial begin
        reset = 1'b1;
        idle(2);
        reset = 1'b0;

        // Edges E1..E4: constant words, back-to-back.
        rd(3'd0, 32'hCAFE_0001);
        rd(3'd1, 32'h5D2F_8C3C);
        rd(3'd6, 32'd4);
        rd(3'd7, 32'h0001_0003);
        // E5..E40 idle, read at E41 sees 40 edges of counting.
        idle(36);
        rd(3'd2, 32'd10);
        wr(3'd5, 32'd0, 4'hF);
        idle(20);
        rd(3'd2, 32'd10);
        rd(3'd5, 32'd0);
        idle(5);
        rd(3'd2, 32'd10);

        // Scratch byte lanes and read-during-write.
        wr(3'd4, 32'hFFFF_FFFF, 4'b0101);
        rd(3'd4, 32'h00FF_00FF);
        rdwr(3'd4, 32'h1234_5678, 32'h00FF_00FF);
        rd(3'd4, 32'h1234_5678);
        wr(3'd0, 32'hDEAD_BEEF, 4'hF);
        rd(3'd0, 32'hCAFE_0001);

        // Snapshot coherence across a carry into the high word.
        wr(3'd5, 32'd1, 4'hF);
        rd(3'd5, 32'd1);
        dut.uptime = 64'h0000_0001_FFFF_FFFF;
        dut.pcnt   = 2'd3;
        rd(3'd2, 32'hFFFF_FFFF);
        rd(3'd3, 32'd1);
        rd(3'd2, 32'd0);
        rd(3'd3, 32'd2);

        // CLR coincident with the terminal count; shadow untouched.
        dut.pcnt = 2'd3;
        wr(3'd5, 32'd3, 4'hF);
        rd(3'd3, 32'd2);
        rd(3'd2, 32'd0);
        idle(2);
        rd(3'd2, 32'd1);
        rd(3'd5, 32'd1);

        // Reset landing on a read-accept edge.
        wr(3'd5, 32'd0, 4'hF);
        chipselect = 1'b1; read = 1'b1; address = 3'd0; reset = 1'b1;
        clk1();
        chipselect = 1'b0; read = 1'b0;
        clk1();
        reset = 1'b0;
        rd(3'd3, 32'd0);
        rd(3'd2, 32'd0);
        rd(3'd4, 32'd0);
        rd(3'd5, 32'd1);
        idle(2);

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
